// File: rtl/flit_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// flit_packetizer_pkg : flit format shared by the packetizer and the flit queue
// Revision 1.0
// ============================================================================
package flit_packetizer_pkg;

   localparam int FLIT_PAYLOAD_W = 16;
   localparam int FLIT_NUM_W     = 4;
   localparam int NODE_ID_W      = 8;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flittype_t;

   typedef struct packed {
      logic [NODE_ID_W-1:0]  src_id;
      logic [NODE_ID_W-1:0]  dst_id;
      flittype_t             flittype;
      logic [FLIT_NUM_W-1:0] flit_num;
   } flit_hdr_t;

   typedef struct packed {
      flit_hdr_t                 header;
      logic [FLIT_PAYLOAD_W-1:0] payload;
   } flit_t;

endpackage
`default_nettype wire

// File: rtl/flit_packetizer_if.sv
`default_nettype none
// ============================================================================
// flit_packetizer_if : message-in / flit-out handshake bundle of the packetizer
// Revision 1.0
// ============================================================================
interface flit_packetizer_if #(
   parameter int MAX_FLITS = 4
);
   import flit_packetizer_pkg::*;

   localparam int LEN_W = $clog2(MAX_FLITS + 1);

   logic                                msg_valid;
   logic                                msg_ready;
   logic [NODE_ID_W-1:0]                msg_src_id;
   logic [NODE_ID_W-1:0]                msg_dst_id;
   logic [LEN_W-1:0]                    msg_len;
   logic [MAX_FLITS*FLIT_PAYLOAD_W-1:0] msg_data;
   flit_t                               flit_out;
   logic                                flit_out_valid;
   logic                                flit_out_ready;
   logic                                busy;

   // slave: the packetizer itself
   modport slave (
      input  msg_valid, msg_src_id, msg_dst_id, msg_len, msg_data, flit_out_ready,
      output msg_ready, flit_out, flit_out_valid, busy
   );

   // master: message source plus downstream flit sink
   modport master (
      output msg_valid, msg_src_id, msg_dst_id, msg_len, msg_data, flit_out_ready,
      input  msg_ready, flit_out, flit_out_valid, busy
   );

endinterface
`default_nettype wire

// File: rtl/flit_packetizer.sv
`default_nettype none
// ============================================================================
// flit_packetizer : turns one message into HEAD + payload flits (last = TAIL)
// Revision 1.0
// ============================================================================
module flit_packetizer
#(
   parameter int MAX_FLITS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   flit_packetizer_if.slave bus
);
   import flit_packetizer_pkg::*;

   localparam int LEN_W = $clog2(MAX_FLITS + 1);

   generate
      if (MAX_FLITS < 1) begin : g_bad_max_flits
         $error("flit_packetizer: MAX_FLITS must be at least 1");
      end
      if (MAX_FLITS + 1 > (1 << FLIT_NUM_W)) begin : g_bad_flit_num_w
         $error("flit_packetizer: FLIT_NUM_W too narrow for MAX_FLITS+1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2
   } state_t;

   state_t                              state_q;
   logic [NODE_ID_W-1:0]                src_q;
   logic [NODE_ID_W-1:0]                dst_q;
   logic [LEN_W-1:0]                    len_q;
   logic [LEN_W-1:0]                    idx_q;
   logic [MAX_FLITS*FLIT_PAYLOAD_W-1:0] data_q;
   flit_t                               flit_q;
   logic                                valid_q;
   logic                                busy_q;

   logic [LEN_W-1:0] len_clamped;
   logic [LEN_W-1:0] body_k;
   logic             last_body;
   logic             hs;
   flit_t            head_flit;
   flit_t            body_flit;

   assign hs                 = valid_q && bus.flit_out_ready;
   assign bus.msg_ready      = (state_q == ST_IDLE) && rst_n;
   assign bus.flit_out       = flit_q;
   assign bus.flit_out_valid = valid_q;
   assign bus.busy           = busy_q;

   // body_k is the payload flit to present after the current handshake
   always_comb begin
      len_clamped = (int'(bus.msg_len) > MAX_FLITS) ? LEN_W'(MAX_FLITS) : bus.msg_len;

      head_flit                 = '0;
      head_flit.header.src_id   = bus.msg_src_id;
      head_flit.header.dst_id   = bus.msg_dst_id;
      head_flit.header.flittype = (len_clamped == '0) ? HEADTAIL : HEAD;
      head_flit.payload         = FLIT_PAYLOAD_W'(len_clamped);

      body_k    = (state_q == ST_BODY) ? (idx_q + LEN_W'(1)) : '0;
      last_body = (idx_q == (len_q - LEN_W'(1)));

      body_flit                 = '0;
      body_flit.header.src_id   = src_q;
      body_flit.header.dst_id   = dst_q;
      body_flit.header.flittype = (body_k == (len_q - LEN_W'(1))) ? TAIL : BODY;
      body_flit.header.flit_num = FLIT_NUM_W'(body_k) + FLIT_NUM_W'(1);
      body_flit.payload         = data_q[int'(body_k)*FLIT_PAYLOAD_W +: FLIT_PAYLOAD_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         flit_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.msg_valid) begin
                  src_q   <= bus.msg_src_id;
                  dst_q   <= bus.msg_dst_id;
                  len_q   <= len_clamped;
                  data_q  <= bus.msg_data;
                  idx_q   <= '0;
                  flit_q  <= head_flit;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_HEAD;
               end
            end
            ST_HEAD: begin
               if (hs) begin
                  if (len_q == '0) begin
                     flit_q  <= '0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     flit_q  <= body_flit;
                     idx_q   <= '0;
                     state_q <= ST_BODY;
                  end
               end
            end
            ST_BODY: begin
               if (hs) begin
                  if (last_body) begin
                     flit_q  <= '0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     flit_q <= body_flit;
                     idx_q  <= body_k;
                  end
               end
            end
            default: begin
               flit_q  <= '0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flit_packetizer.sv
`default_nettype none
// ============================================================================
// tb_flit_packetizer : directed self-checking bench for flit_packetizer
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_flit_packetizer;
   import flit_packetizer_pkg::*;

   localparam int MAX_FLITS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   flit_packetizer_if #(.MAX_FLITS(MAX_FLITS)) bus ();

   flit_packetizer #(.MAX_FLITS(MAX_FLITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic flit_t mk(input flittype_t t, input logic [7:0] s, input logic [7:0] d,
                                input int n, input logic [15:0] p);
      flit_t f;
      f                 = '0;
      f.header.src_id   = s;
      f.header.dst_id   = d;
      f.header.flittype = t;
      f.header.flit_num = FLIT_NUM_W'(n);
      f.payload         = p;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flit(input string tag, input flit_t exp);
      check({tag, "_valid"}, 64'(bus.flit_out_valid), 64'(1));
      check({tag, "_flit"}, 64'(bus.flit_out), 64'(exp));
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_valid"}, 64'(bus.flit_out_valid), 64'(0));
      check({tag, "_flit"}, 64'(bus.flit_out), 64'(0));
      check({tag, "_busy"}, 64'(bus.busy), 64'(0));
      check({tag, "_ready"}, 64'(bus.msg_ready), 64'(1));
   endtask

   task automatic offer(input logic [7:0] s, input logic [7:0] d, input logic [2:0] len,
                        input logic [63:0] data);
      bus.msg_valid  = 1'b1;
      bus.msg_src_id = s;
      bus.msg_dst_id = d;
      bus.msg_len    = len;
      bus.msg_data   = data;
   endtask

   flit_t exp4 [5];
   flit_t sent [$];

   initial begin
      int  got;
      bit  done;
      bus.msg_valid      = 1'b0;
      bus.msg_src_id     = '0;
      bus.msg_dst_id     = '0;
      bus.msg_len        = '0;
      bus.msg_data       = '0;
      bus.flit_out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.flit_out_valid), 64'(0));
      check("rst_flit", 64'(bus.flit_out), 64'(0));
      check("rst_msg_ready", 64'(bus.msg_ready), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      rst_n = 1'b1;
      tick();
      chk_idle("rst_rel");

      // 1: len=2 with downstream always ready
      offer(8'h01, 8'h02, 3'd2, 64'h0000_0000_BBBB_AAAA);
      tick();
      bus.msg_valid = 1'b0;
      chk_flit("t1_head", mk(HEAD, 8'h01, 8'h02, 0, 16'd2));
      check("t1_busy", 64'(bus.busy), 64'(1));
      check("t1_msg_ready", 64'(bus.msg_ready), 64'(0));
      tick();
      chk_flit("t1_body", mk(BODY, 8'h01, 8'h02, 1, 16'hAAAA));
      tick();
      chk_flit("t1_tail", mk(TAIL, 8'h01, 8'h02, 2, 16'hBBBB));
      tick();
      chk_idle("t1_end");

      // 2: empty message -> single HEADTAIL
      offer(8'h03, 8'h04, 3'd0, 64'hDEAD_BEEF_1234_5678);
      tick();
      bus.msg_valid = 1'b0;
      chk_flit("t2_headtail", mk(HEADTAIL, 8'h03, 8'h04, 0, 16'd0));
      check("t2_busy", 64'(bus.busy), 64'(1));
      tick();
      chk_idle("t2_end");

      // 3: HEAD stalled 4 cycles; msg_* changes meanwhile must be ignored
      bus.flit_out_ready = 1'b0;
      offer(8'h0C, 8'h0D, 3'd3, 64'h0000_3333_2222_1111);
      tick();
      offer(8'hFF, 8'hEE, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         chk_flit("t3_hold", mk(HEAD, 8'h0C, 8'h0D, 0, 16'd3));
         check("t3_msg_ready", 64'(bus.msg_ready), 64'(0));
         if (i < 3) tick();
      end
      bus.flit_out_ready = 1'b1;
      bus.msg_valid      = 1'b0;
      tick();
      chk_flit("t3_b1", mk(BODY, 8'h0C, 8'h0D, 1, 16'h1111));
      check("t3_msg_ready_b", 64'(bus.msg_ready), 64'(0));
      tick();
      chk_flit("t3_b2", mk(BODY, 8'h0C, 8'h0D, 2, 16'h2222));
      tick();
      chk_flit("t3_tail", mk(TAIL, 8'h0C, 8'h0D, 3, 16'h3333));
      tick();
      chk_idle("t3_end");

      // 4: alternating ready, oversize len clamped to MAX_FLITS
      exp4[0] = mk(HEAD, 8'h0E, 8'h0F, 0, 16'd4);
      exp4[1] = mk(BODY, 8'h0E, 8'h0F, 1, 16'h4444);
      exp4[2] = mk(BODY, 8'h0E, 8'h0F, 2, 16'h5555);
      exp4[3] = mk(BODY, 8'h0E, 8'h0F, 3, 16'h6666);
      exp4[4] = mk(TAIL, 8'h0E, 8'h0F, 4, 16'h7777);
      offer(8'h0E, 8'h0F, 3'd7, 64'h7777_6666_5555_4444);
      tick();
      bus.msg_valid = 1'b0;
      got  = 0;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         bus.flit_out_ready = ((c % 2) == 1);
         check("t4_valid", 64'(bus.flit_out_valid), 64'(1));
         if (got < 5) check("t4_flit", 64'(bus.flit_out), 64'(exp4[got]));
         if (bus.flit_out_valid && bus.flit_out_ready) begin
            got++;
            if (got == 5) done = 1'b1;
         end
         tick();
      end
      check("t4_count", 64'(got), 64'(5));
      bus.flit_out_ready = 1'b1;
      chk_idle("t4_end");

      // 5: asynchronous reset in the middle of a body
      offer(8'h08, 8'h09, 3'd4, 64'h1111_2222_3333_4444);
      tick();
      bus.msg_valid = 1'b0;
      tick();
      chk_flit("t5_body", mk(BODY, 8'h08, 8'h09, 1, 16'h4444));
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 64'(bus.flit_out_valid), 64'(0));
      check("t5_rst_busy", 64'(bus.busy), 64'(0));
      check("t5_rst_flit", 64'(bus.flit_out), 64'(0));
      check("t5_rst_msg_ready", 64'(bus.msg_ready), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle("t5_rel");
      offer(8'h0A, 8'h0B, 3'd1, 64'h0000_0000_0000_CAFE);
      tick();
      bus.msg_valid = 1'b0;
      chk_flit("t5_head", mk(HEAD, 8'h0A, 8'h0B, 0, 16'd1));
      tick();
      chk_flit("t5_tail", mk(TAIL, 8'h0A, 8'h0B, 1, 16'hCAFE));
      tick();
      chk_idle("t5_end");

      // 6: msg_valid held for two back-to-back messages; order via a FIFO model
      offer(8'h05, 8'h50, 3'd1, 64'h0000_0000_0000_0505);
      tick();
      offer(8'h06, 8'h60, 3'd1, 64'h0000_0000_0000_0606);
      for (int c = 0; c < 5; c++) begin
         if (c == 3) bus.msg_valid = 1'b0;
         if (bus.flit_out_valid && bus.flit_out_ready) sent.push_back(bus.flit_out);
         if (c == 2) begin
            check("t6_gap_valid", 64'(bus.flit_out_valid), 64'(0));
            check("t6_gap_msg_ready", 64'(bus.msg_ready), 64'(1));
         end
         tick();
      end
      check("t6_count", 64'(sent.size()), 64'(4));
      if (sent.size() == 4) begin
         check("t6_pop0", 64'(sent.pop_front()), 64'(mk(HEAD, 8'h05, 8'h50, 0, 16'd1)));
         check("t6_pop1", 64'(sent.pop_front()), 64'(mk(TAIL, 8'h05, 8'h50, 1, 16'h0505)));
         check("t6_pop2", 64'(sent.pop_front()), 64'(mk(HEAD, 8'h06, 8'h60, 0, 16'd1)));
         check("t6_pop3", 64'(sent.pop_front()), 64'(mk(TAIL, 8'h06, 8'h60, 1, 16'h0606)));
      end
      chk_idle("t6_end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
